addseq_ctrl: RTL and testbench

//  Sequencer that time-shares one external 4-bit full-adder slice (cin,a,b -> sum,cout)
//  to add wide operands nibble by nibble, LSB first, chaining carry between cycles.

---
 rtl/addseq_if.sv | 44 ++++
 rtl/addseq_ctrl.sv | 125 ++++++++++++
 tb/tb_addseq_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/addseq_if.sv
// Requester and adder-slice signal bundle for addseq_ctrl.
// The optional sub request bit exists only when SUBTRACT_EN is defined.
interface addseq_if #(
    parameter int unsigned WORDS = 4
);
    localparam int unsigned W = 4 * WORDS;

    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
`ifdef SUBTRACT_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic [3:0]   fa_a;
    logic [3:0]   fa_b;
    logic         fa_cin;
    logic [3:0]   fa_sum;
    logic         fa_cout;

    // Sequencer side: consumes requests and adder results, drives status and slice operands
    modport slave (
        input  start, op_a, op_b, cin,
`ifdef SUBTRACT_EN
        input  sub,
`endif
        input  fa_sum, fa_cout,
        output busy, done, sum, cout, ovf, fa_a, fa_b, fa_cin
    );

    modport master (
        output start, op_a, op_b, cin,
`ifdef SUBTRACT_EN
        output sub,
`endif
        output fa_sum, fa_cout,
        input  busy, done, sum, cout, ovf, fa_a, fa_b, fa_cin
    );
endinterface

// File: rtl/addseq_ctrl.sv
// Nibble-serial adder sequencer: time-shares one external 4-bit adder slice, LSB nibble first.
// Define SUBTRACT_EN to add the sub request bit (A - B via inverted B and forced carry-in).
module addseq_ctrl #(
    parameter int unsigned WORDS = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    addseq_if.slave  bus
);
    localparam int unsigned W  = 4 * WORDS;
    localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [WORDS-1:0][3:0]   a_q, a_d;
    logic [WORDS-1:0][3:0]   b_q, b_d;
    logic                    c_q, c_d;
    logic [WORDS-1:0][3:0]   sum_q, sum_d;
    logic                    cout_q, cout_d;
    logic                    ovf_q, ovf_d;
    logic                    busy_q, done_q;
    logic [3:0]              fa_a_c, fa_b_c;
    logic                    fa_cin_c;
    logic                    last_c;

    assign last_c = (idx_q == IW'(WORDS - 1));

    // State register plus latched operands, running carry and result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    // Next state, operand capture and one nibble of the result per RUN cycle
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        fa_a_c   = 4'h0;
        fa_b_c   = 4'h0;
        fa_cin_c = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    a_d     = bus.op_a;
                    sum_d   = '0;
`ifdef SUBTRACT_EN
                    if (bus.sub) begin
                        b_d = ~bus.op_b;
                        c_d = 1'b1;
                    end else begin
                        b_d = bus.op_b;
                        c_d = bus.cin;
                    end
`else
                    b_d     = bus.op_b;
                    c_d     = bus.cin;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                fa_a_c        = a_q[idx_q];
                fa_b_c        = b_q[idx_q];
                fa_cin_c      = c_q;
                sum_d[idx_q]  = bus.fa_sum;
                c_d           = bus.fa_cout;
                idx_d         = idx_q + IW'(1);
                if (last_c) begin
                    state_d = DONE;
                    idx_d   = '0;
                    cout_d  = bus.fa_cout;
                    ovf_d   = (a_q[WORDS-1][3] == b_q[WORDS-1][3]) &&
                              (bus.fa_sum[3] != a_q[WORDS-1][3]);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.sum    = sum_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;
    assign bus.fa_a   = fa_a_c;
    assign bus.fa_b   = fa_b_c;
    assign bus.fa_cin = fa_cin_c;
endmodule

// File: tb/tb_addseq_ctrl.sv
// Bench for addseq_ctrl (WORDS=4): directed, random, back-to-back and mid-run reset scenarios
// against a whole-word arithmetic reference model; the adder slice is modelled here.
module tb_addseq_ctrl;
    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = 4 * WORDS;
    localparam int unsigned W1    = W + 1;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    addseq_if #(.WORDS(WORDS)) bus ();

    addseq_ctrl #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // External 4-bit adder slice
    logic [4:0] slice_res;
    assign slice_res   = 5'(bus.fa_a) + 5'(bus.fa_b) + 5'(bus.fa_cin);
    assign bus.fa_sum  = slice_res[3:0];
    assign bus.fa_cout = slice_res[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {ovf, cout, sum} from whole-word arithmetic
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic c, input logic s);
        logic [W-1:0] be;
        logic         ce;
        logic [W:0]   full;
        be   = s ? ~b : b;
        ce   = s ? 1'b1 : c;
        full = W1'(a) + W1'(be) + W1'(ce);
        return {(a[W-1] == be[W-1]) && (full[W-1] != a[W-1]), full[W], full[W-1:0]};
    endfunction

    function automatic logic [3:0] nib(input logic [W-1:0] x, input int k);
        logic [W-1:0] t;
        t = x >> (4 * k);
        return t[3:0];
    endfunction

    logic [3:0] fa_seq [WORDS];

    // Issue one operation and wait (bounded) for done; fa_a is recorded per busy cycle
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic s, output int busy_cnt, output logic got_done);
        @(negedge clk);
        bus.op_a  = a;
        bus.op_b  = b;
        bus.cin   = c;
`ifdef SUBTRACT_EN
        bus.sub   = s;
`endif
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        busy_cnt  = 0;
        got_done  = 1'b0;
        for (int k = 0; k < 20 && !got_done; k++) begin
            if (bus.busy) begin
                if (busy_cnt < int'(WORDS)) fa_seq[busy_cnt] = bus.fa_a;
                busy_cnt++;
            end
            if (bus.done) got_done = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.cin   = 1'b0;
`ifdef SUBTRACT_EN
        bus.sub   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf, bus.fa_a, bus.fa_b, bus.fa_cin} !== '0)
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b fa_a=%h fa_b=%h fa_cin=%b, want all 0",
                     bus.busy, bus.done, bus.sum, bus.cout, bus.ovf, bus.fa_a, bus.fa_b, bus.fa_cin);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.sum} !== '0)
            $display("FAIL idle_after_reset: got busy=%b done=%b sum=%h, want 0 0 0000", bus.busy, bus.done, bus.sum);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [W-1:0] va [4] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000};
        logic [W-1:0] vb [4] = '{16'h0FFF, 16'h0000, 16'h0001, 16'h8000};
        logic         vc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [W+1:0] want [4] = '{{2'b00, 16'h2233}, {2'b01, 16'h0000}, {2'b10, 16'h8000}, {2'b11, 16'h0000}};
        int   bc;
        logic gd;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], vc[i], 1'b0, bc, gd);
            n_checks++;
            if (!gd || bc != int'(WORDS))
                $display("FAIL directed%0d_latency: got done=%b busy_cycles=%0d, want 1 %0d", i, gd, bc, WORDS);
            else n_pass++;
            n_checks++;
            if ({bus.ovf, bus.cout, bus.sum} !== want[i])
                $display("FAIL directed%0d_result: got ovf=%b cout=%b sum=%h, want ovf=%b cout=%b sum=%h",
                         i, bus.ovf, bus.cout, bus.sum, want[i][W+1], want[i][W], want[i][W-1:0]);
            else n_pass++;
            n_checks++;
            if (fa_seq[0] !== nib(va[i], 0) || fa_seq[1] !== nib(va[i], 1) ||
                fa_seq[2] !== nib(va[i], 2) || fa_seq[3] !== nib(va[i], 3))
                $display("FAIL directed%0d_fa_a_seq: got %h %h %h %h, want nibbles of %h LSB first",
                         i, fa_seq[0], fa_seq[1], fa_seq[2], fa_seq[3], va[i]);
            else n_pass++;
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.ovf, bus.cout, bus.sum, bus.done, bus.fa_a} !== {want[3], 1'b0, 4'h0})
            $display("FAIL idle_hold: got ovf=%b cout=%b sum=%h done=%b fa_a=%h, want result held, done=0, fa_a=0",
                     bus.ovf, bus.cout, bus.sum, bus.done, bus.fa_a);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic         c, s;
        logic [W+1:0] want;
        int   bc;
        logic gd;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom);
`ifdef SUBTRACT_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            want = ref_add(a, b, c, s);
            do_op(a, b, c, s, bc, gd);
            n_checks++;
            if (!gd || bc != int'(WORDS) || {bus.ovf, bus.cout, bus.sum} !== want)
                $display("FAIL random%0d a=%h b=%h c=%b s=%b: got done=%b cyc=%0d ovf=%b cout=%b sum=%h, want ovf=%b cout=%b sum=%h",
                         i, a, b, c, s, gd, bc, bus.ovf, bus.cout, bus.sum, want[W+1], want[W], want[W-1:0]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] xa, xb, ya, yb;
        logic [W+1:0] wx, wy;
        logic         exp_busy, exp_done;
        logic [3:0]   exp_fa;
        xa = W'($urandom); xb = W'($urandom);
        ya = W'($urandom); yb = W'($urandom);
        wx = ref_add(xa, xb, 1'b0, 1'b0);
        wy = ref_add(ya, yb, 1'b1, 1'b0);
        @(negedge clk);
        bus.op_a = xa; bus.op_b = xb; bus.cin = 1'b0;
`ifdef SUBTRACT_EN
        bus.sub = 1'b0;
`endif
        bus.start = 1'b1;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            exp_busy = (k < 4) || (k >= 5 && k < 9);
            exp_done = (k == 4) || (k == 9);
            exp_fa   = (k < 4) ? nib(xa, k) : ((k >= 5 && k < 9) ? nib(ya, k - 5) : 4'h0);
            n_checks++;
            if (bus.busy !== exp_busy || bus.done !== exp_done || bus.fa_a !== exp_fa)
                $display("FAIL b2b_cycle%0d: got busy=%b done=%b fa_a=%h, want busy=%b done=%b fa_a=%h",
                         k, bus.busy, bus.done, bus.fa_a, exp_busy, exp_done, exp_fa);
            else n_pass++;
            if (k == 4 || k == 9) begin
                n_checks++;
                if ({bus.ovf, bus.cout, bus.sum} !== ((k == 4) ? wx : wy))
                    $display("FAIL b2b_result%0d: got ovf=%b cout=%b sum=%h, want %h",
                             k, bus.ovf, bus.cout, bus.sum, (k == 4) ? wx : wy);
                else n_pass++;
            end
            if (k == 0) begin
                bus.op_a = ya; bus.op_b = yb; bus.cin = 1'b1;
            end
            if (k == 6) bus.start = 1'b0;
        end
    endtask

    task automatic test_reset_mid_run();
        int seen_done;
        @(negedge clk);
        bus.op_a = 16'h1111; bus.op_b = 16'h2222; bus.cin = 1'b0;
`ifdef SUBTRACT_EN
        bus.sub = 1'b0;
`endif
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b1 || bus.fa_a !== 4'h1 || bus.sum[7:0] !== 8'h33)
            $display("FAIL midrun_pre: got busy=%b fa_a=%h sum=%h, want busy=1 fa_a=1 sum[7:0]=33",
                     bus.busy, bus.fa_a, bus.sum);
        else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf, bus.fa_a, bus.fa_b, bus.fa_cin} !== '0)
            $display("FAIL midrun_async_reset: got busy=%b done=%b sum=%h cout=%b ovf=%b fa_a=%h, want all 0",
                     bus.busy, bus.done, bus.sum, bus.cout, bus.ovf, bus.fa_a);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen_done++;
        end
        n_checks++;
        if (seen_done != 0)
            $display("FAIL midrun_no_done: got %0d cycles with busy/done after reset, want 0", seen_done);
        else n_pass++;
    endtask

`ifdef SUBTRACT_EN
    task automatic test_subtract();
        int   bc;
        logic gd;
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, bc, gd);
        n_checks++;
        if (!gd || bus.sum !== 16'hFFFE || bus.cout !== 1'b0)
            $display("FAIL sub_borrow: got done=%b sum=%h cout=%b, want 1 FFFE 0", gd, bus.sum, bus.cout);
        else n_pass++;
        do_op(16'h0007, 16'h0005, 1'b0, 1'b1, bc, gd);
        n_checks++;
        if (!gd || bus.sum !== 16'h0002 || bus.cout !== 1'b1)
            $display("FAIL sub_noborrow: got done=%b sum=%h cout=%b, want 1 0002 1", gd, bus.sum, bus.cout);
        else n_pass++;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
`ifdef SUBTRACT_EN
        test_subtract();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
